// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer:
// state codes, opcode values and ALU function encodings.
package cpu_ctrl_pkg;

    // State codes are visible on state_out, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_JUMP   = 4'd5,
        ST_HALT   = 4'd6,
        ST_ERROR  = 4'd7
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_JUMP  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Watchdog timer width; covers the full TIMEOUT range 1..255.
    localparam int TIMER_W = 8;

    // The ALU opcodes were chosen so their low two bits are the ALU function.
    function automatic logic [1:0] alu_from_opcode(input logic [2:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/cpu_control_sequencer_watchdog.sv
// Memory-access watchdog: counts consecutive request cycles that went
// unacknowledged and flags the cycle on which the TIMEOUT-th one occurs.
module mem_watchdog
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic Clock,
    input  logic Clear,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam logic [TIMER_W-1:0] LP_LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] r_timer;

    // The timeout is combinational so the sequencer can divert to ERROR
    // right after the last permitted unacknowledged cycle.
    assign o_timeout = i_count && (r_timer == LP_LAST);

    // Timer: restart on entry to a request state, advance on each miss.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_count) begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 3-bit-opcode CPU.
// Optional build macro SINGLE_STEP_EN adds the 'step' input: each
// instruction then ends in IDLE and needs run=1 with step=1 to fetch again.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 8
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               run,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [1:0]         alu_op,
    output logic               reg_we,
    output logic               reg_src,
    output logic               halted,
    output logic               error,
    output logic [3:0]         state_out
);

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_boundary_state;
    logic [2:0] r_opcode;
    logic       w_start;
    logic       w_req_cycle;
    logic       w_wd_count;
    logic       w_wd_clear;
    logic       w_timeout;
    logic       w_unused_rdata;

    // Only the opcode field is consumed here; the datapath uses the rest.
    assign w_unused_rdata = ^mem_rdata[INSTR_W-4:0];

`ifdef SINGLE_STEP_EN
    assign w_start          = run && step;
    assign w_boundary_state = ST_IDLE;
`else
    assign w_start          = run;
    assign w_boundary_state = run ? ST_FETCH : ST_IDLE;
`endif

    // Derived from state alone (not from the output decode) to keep the
    // watchdog path free of combinational feedback.
    assign w_req_cycle = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_wd_count  = w_req_cycle && !mem_ack;
    assign w_wd_clear  = (w_state_next != r_state) &&
                         ((w_state_next == ST_FETCH) || (w_state_next == ST_MEM));

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .Clock     (Clock),
        .Clear     (Clear),
        .i_clear   (w_wd_clear),
        .i_count   (w_wd_count),
        .o_timeout (w_timeout)
    );

    // State register and opcode capture on the acknowledged fetch.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state  <= ST_IDLE;
            r_opcode <= OP_ADD;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_FETCH && mem_ack) begin
                r_opcode <= mem_rdata[INSTR_W-1 -: 3];
            end
        end
    end

    // Next-state and output decode; ack-qualified strobes are Mealy.
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        alu_op       = ALU_ADD;
        reg_we       = 1'b0;
        reg_src      = 1'b0;
        halted       = 1'b0;
        error        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_DECODE: begin
                case (r_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_state_next = ST_EXEC;
                    OP_LOAD, OP_STORE:             w_state_next = ST_MEM;
                    OP_JUMP:                       w_state_next = ST_JUMP;
                    default:                       w_state_next = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                alu_op       = alu_from_opcode(r_opcode);
                reg_we       = 1'b1;
                w_state_next = w_boundary_state;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (r_opcode == OP_STORE);
                if (mem_ack) begin
                    if (r_opcode == OP_LOAD) begin
                        reg_we  = 1'b1;
                        reg_src = 1'b1;
                    end
                    w_state_next = w_boundary_state;
                end else if (w_timeout) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_JUMP: begin
                pc_load      = 1'b1;
                w_state_next = w_boundary_state;
            end
            ST_HALT:  halted = 1'b1;
            ST_ERROR: error  = 1'b1;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign state_out = r_state;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer (TIMEOUT=4). Expected output
// vectors are queued as each cycle's stimulus is driven and popped when the
// outputs are sampled on the falling edge.
module tb_cpu_control_sequencer;

    typedef struct {
        logic        run;
        logic        step;
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] exp;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        run = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [1:0]  alu_op;
    logic        reg_we, reg_src, halted, error;
    logic [3:0]  state_out;

    logic [15:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    wire logic [15:0] obs = {state_out, mem_req, mem_we, addr_sel, ir_load, pc_inc,
                             pc_load, alu_op, reg_we, reg_src, halted, error};

    cpu_control_sequencer #(
        .INSTR_W (16),
        .TIMEOUT (4)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .reg_src   (reg_src),
        .halted    (halted),
        .error     (error),
        .state_out (state_out)
    );

    always #5 Clock = ~Clock;

    // Expected-vector builders, one per state/condition.
    function automatic logic [15:0] ev(input logic [3:0] st, input logic req, we, asel,
                                       irl, pci, pcl, input logic [1:0] alu,
                                       input logic rwe, rsrc, hlt, err);
        return {st, req, we, asel, irl, pci, pcl, alu, rwe, rsrc, hlt, err};
    endfunction
    function automatic logic [15:0] e_idle();
        return ev(4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_fetch(input logic ack);
        return ev(4'd1, 1, 0, 0, ack, ack, 0, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_dec();
        return ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_exec(input logic [1:0] alu);
        return ev(4'd3, 0, 0, 0, 0, 0, 0, alu, 1, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_mem(input logic store, input logic ack);
        return ev(4'd4, 1, store, 1, 0, 0, 0, 2'b00, ack & ~store, ack & ~store, 0, 0);
    endfunction
    function automatic logic [15:0] e_jump();
        return ev(4'd5, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_halt();
        return ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    endfunction
    function automatic logic [15:0] e_err();
        return ev(4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    endfunction

    function automatic logic [15:0] ins(input logic [2:0] op);
        return {op, 13'h0a5};
    endfunction
    function automatic vec_t vv(input logic r, s, a, input logic [15:0] d, e);
        vec_t v;
        v.run = r; v.step = s; v.ack = a; v.rdata = d; v.exp = e;
        return v;
    endfunction

    // Drive one cycle's inputs and queue the outputs that cycle must show.
    task automatic apply(input vec_t v);
        run       = v.run;
        mem_ack   = v.ack;
        mem_rdata = v.rdata;
`ifdef SINGLE_STEP_EN
        step      = v.step;
`endif
        sb.push_back(v.exp);
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        Clear = 1'b1; run = 1'b0; mem_ack = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        repeat (2) @(posedge Clock);
        #1 Clear = 1'b0;
    endtask

    task automatic test_reset();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(0, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_seq[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
        // Clear mid-FETCH with an ack present: no ir_load may escape.
        mem_ack = 1'b1; mem_rdata = ins(3'b111); Clear = 1'b1;
        sb.push_back(e_idle());
        #1;
        e = sb.pop_front(); n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_async got %h expected %h", obs, e);
        end
        @(posedge Clock); #1;
        sb.push_back(e_idle());
        @(negedge Clock);
        e = sb.pop_front(); n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_hold got %h expected %h", obs, e);
        end
        @(posedge Clock); #1;
        Clear = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_alu();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 1, ins(3'b000), e_fetch(1)));
        s.push_back(vv(1, 1, 1, ins(3'b111), e_dec()));
        s.push_back(vv(1, 1, 1, ins(3'b111), e_exec(2'b00)));
        s.push_back(vv(1, 1, 1, ins(3'b001), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b111), e_dec()));
        s.push_back(vv(0, 1, 0, ins(3'b111), e_exec(2'b01)));
        s.push_back(vv(0, 1, 1, ins(3'b111), e_idle()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL alu_add_sub[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_mem();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 1, ins(3'b100), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_mem(0, 0)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_mem(0, 0)));
        s.push_back(vv(1, 1, 1, ins(3'b000), e_mem(0, 1)));
        s.push_back(vv(1, 1, 1, ins(3'b101), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_mem(1, 0)));
        s.push_back(vv(0, 1, 1, ins(3'b000), e_mem(1, 1)));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_idle()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL load_store[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_jump_halt();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 1, ins(3'b110), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_jump()));
        s.push_back(vv(1, 1, 1, ins(3'b111), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_halt()));
        s.push_back(vv(1, 1, 1, ins(3'b000), e_halt()));
        s.push_back(vv(0, 1, 1, ins(3'b000), e_halt()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_halt()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL jump_halt[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_run_drop();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 1, ins(3'b011), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_exec(2'b11)));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 1, ins(3'b010), e_fetch(1)));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_exec(2'b10)));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_idle()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL run_drop[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_timeout();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 1, ins(3'b000), e_err()));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_err()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL timeout_trap[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
        // Ack arriving on the last permitted cycle is honoured.
        do_reset();
        s.delete();
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_fetch(0)));
        s.push_back(vv(1, 1, 1, ins(3'b001), e_fetch(1)));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_dec()));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_exec(2'b01)));
        s.push_back(vv(0, 1, 0, ins(3'b000), e_idle()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL timeout_edge_ack[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        vec_t s[$];
        logic [15:0] e;
        do_reset();
        s.push_back(vv(1, 0, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 0, 1, ins(3'b000), e_fetch(1)));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_dec()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_exec(2'b00)));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 1, 0, ins(3'b000), e_idle()));
        s.push_back(vv(1, 0, 1, ins(3'b001), e_fetch(1)));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_dec()));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_exec(2'b01)));
        s.push_back(vv(1, 0, 0, ins(3'b000), e_idle()));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge Clock);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL single_step[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge Clock); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SINGLE_STEP_EN
        test_single_step();
`else
        test_alu();
        test_mem();
        test_jump_halt();
        test_run_drop();
`endif
        test_timeout();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d leftover expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
